// File: rtl/spgd_pkg.sv
// Shared types and saturating fixed-point helpers for the N-channel SPGD core.
package spgd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PERT  = 4'd1,
    ST_SETP  = 4'd2,
    ST_SAMPP = 4'd3,
    ST_SETM  = 4'd4,
    ST_SAMPM = 4'd5,
    ST_GAIN  = 4'd6,
    ST_STEP  = 4'd7,
    ST_UPD   = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    SS_IDLE   = 2'd0,
    SS_SETTLE = 2'd1,
    SS_WAIT   = 2'd2
  } smp_state_t;

  // Galois LFSR feedback mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Helpers work on widened words so any FP_WIDTH up to 64 is supported
  localparam int unsigned XW = 64;
  typedef logic signed [XW-1:0]   xw_t;
  typedef logic signed [2*XW-1:0] pw_t;

  function automatic xw_t sat_w(input pw_t x, input int unsigned w);
    pw_t hi;
    pw_t lo;
    hi = (pw_t'(1) <<< (w - 1)) - pw_t'(1);
    lo = -hi - pw_t'(1);
    if (x > hi) return xw_t'(hi);
    if (x < lo) return xw_t'(lo);
    return xw_t'(x);
  endfunction

  function automatic xw_t sat_add(input xw_t a, input xw_t b, input int unsigned w);
    return sat_w(pw_t'(a) + pw_t'(b), w);
  endfunction

  function automatic xw_t sat_sub(input xw_t a, input xw_t b, input int unsigned w);
    return sat_w(pw_t'(a) - pw_t'(b), w);
  endfunction

  function automatic xw_t sat_mul_q(input xw_t a, input xw_t b, input int unsigned w,
                                    input int unsigned frac);
    pw_t p;
    p = pw_t'(a) * pw_t'(b);
    return sat_w(p >>> frac, w);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/spgd_multi_core_sampler.sv
// Settle countdown, one-cycle ADC request and bounded wait for the sample strobe.
module spgd_settle_sampler
  import spgd_pkg::*;
#(
  parameter int unsigned ADC_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] settle_cyc,
  input  logic        adc_done,
  output logic        adc_en,
  output logic        fire_c,
  output logic        got_c,
  output logic        tmo_c
);

  localparam int unsigned TW = $clog2(ADC_TIMEOUT + 1);

  smp_state_t    state, state_nxt;
  logic [15:0]   cnt, cnt_nxt;
  logic [TW-1:0] wcnt, wcnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SS_IDLE;
      cnt    <= '0;
      wcnt   <= '0;
      adc_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      wcnt   <= wcnt_nxt;
      adc_en <= fire_c;
    end
  end

  // A start request always wins so a new phase can begin on the capture cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wcnt_nxt  = wcnt;
    fire_c    = 1'b0;
    got_c     = 1'b0;
    tmo_c     = 1'b0;
    case (state)
      SS_SETTLE: begin
        if (cnt == 16'd0) begin
          fire_c    = 1'b1;
          state_nxt = SS_WAIT;
          wcnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      SS_WAIT: begin
        if (adc_done) begin
          got_c     = 1'b1;
          state_nxt = SS_IDLE;
        end else if (wcnt == TW'(ADC_TIMEOUT - 1)) begin
          tmo_c     = 1'b1;
          state_nxt = SS_IDLE;
        end else begin
          wcnt_nxt = wcnt + TW'(1);
        end
      end
      default: state_nxt = SS_IDLE;
    endcase
    if (start) begin
      state_nxt = SS_SETTLE;
      cnt_nxt   = settle_cyc;
    end
  end

endmodule

// File: rtl/spgd_multi_core.sv
// N-channel SPGD optimiser: perturb, sample J at U+d and U-d, then serial gain update.
module spgd_multi_core
  import spgd_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned FP_WIDTH    = 32,
  parameter int unsigned FRAC_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  parameter int unsigned ADC_TIMEOUT = 4096,
  parameter logic [FP_WIDTH-1:0] U_RST_VAL = '0
) (
  input  logic                         ADC_CLK,
  input  logic                         REG_RST,
  input  logic                         SYS_EN,
  input  logic                         MODE,
  input  logic signed [FP_WIDTH-1:0]   ADC_IN,
  input  logic                         ADC_DONE,
  output logic                         ADC_EN,
  input  logic signed [FP_WIDTH-1:0]   SIGMA,
  input  logic signed [FP_WIDTH-1:0]   GAMMA,
  input  logic signed [FP_WIDTH-1:0]   U_MIN,
  input  logic signed [FP_WIDTH-1:0]   U_MAX,
  input  logic [15:0]                  SETTLE_CYC,
  output logic [N_CH*FP_WIDTH-1:0]     DAC_OUT,
  output logic [N_CH*FP_WIDTH-1:0]     U_OUT,
  output logic [31:0]                  ITER_CNT,
  output logic                         BUSY,
  output logic                         ADC_ERR,
  output logic [3:0]                   FSM_STATE
);

  localparam int unsigned W  = FP_WIDTH;
  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t              state, state_nxt;
  logic [31:0]         lfsr, lfsr_nxt;
  logic signed [W-1:0] u [N_CH];
  logic signed [W-1:0] j_p, j_m, g, step;
  logic signed [W-1:0] dj_raw_c, dj_c, sum_c, upd_c;
  logic [IW-1:0]       idx;
  logic [31:0]         iter_cnt;
  logic                busy, adc_err;
  logic                start_c, fire_c, got_c, tmo_c;

  spgd_settle_sampler #(.ADC_TIMEOUT(ADC_TIMEOUT)) u_sampler (
    .clk        (ADC_CLK),
    .rst        (REG_RST),
    .start      (start_c),
    .settle_cyc (SETTLE_CYC),
    .adc_done   (ADC_DONE),
    .adc_en     (ADC_EN),
    .fire_c     (fire_c),
    .got_c      (got_c),
    .tmo_c      (tmo_c)
  );

  always_ff @(posedge ADC_CLK or posedge REG_RST) begin
    if (REG_RST) begin
      state    <= ST_IDLE;
      lfsr     <= LFSR_SEED;
      for (int k = 0; k < N_CH; k++) u[k] <= U_RST_VAL;
      j_p      <= '0;
      j_m      <= '0;
      g        <= '0;
      step     <= '0;
      idx      <= '0;
      iter_cnt <= '0;
      busy     <= 1'b0;
      adc_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      busy  <= (state_nxt != ST_IDLE);
      if (state == ST_SAMPP && got_c) j_p <= ADC_IN;
      if (state == ST_SAMPM && got_c) j_m <= ADC_IN;
      if ((state == ST_SAMPP || state == ST_SAMPM) && tmo_c) adc_err <= 1'b1;
      if (state == ST_GAIN) g <= W'(sat_mul_q(xw_t'(dj_c), xw_t'(GAMMA), W, FRAC_WIDTH));
      if (state == ST_STEP) begin
        step <= W'(sat_mul_q(xw_t'(g), xw_t'(SIGMA), W, FRAC_WIDTH));
        idx  <= '0;
      end
      if (state == ST_UPD) begin
        u[idx] <= upd_c;
        idx    <= idx + IW'(1);
        if (idx == IW'(N_CH - 1)) iter_cnt <= iter_cnt + 32'd1;
      end
    end
  end

  // Next-state logic; a timeout abandons the iteration without touching U
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    start_c   = 1'b0;
    case (state)
      ST_IDLE:  if (SYS_EN) state_nxt = ST_PERT;
      ST_PERT: begin
        if (!SYS_EN) begin
          state_nxt = ST_IDLE;
        end else begin
          lfsr_nxt  = lfsr_next(lfsr);
          start_c   = 1'b1;
          state_nxt = ST_SETP;
        end
      end
      ST_SETP:  if (fire_c) state_nxt = ST_SAMPP;
      ST_SAMPP: begin
        if (got_c) begin
          start_c   = 1'b1;
          state_nxt = ST_SETM;
        end else if (tmo_c) begin
          state_nxt = ST_PERT;
        end
      end
      ST_SETM:  if (fire_c) state_nxt = ST_SAMPM;
      ST_SAMPM: begin
        if (got_c)      state_nxt = ST_GAIN;
        else if (tmo_c) state_nxt = ST_PERT;
      end
      ST_GAIN:  state_nxt = ST_STEP;
      ST_STEP:  state_nxt = ST_UPD;
      ST_UPD:   if (idx == IW'(N_CH - 1)) state_nxt = ST_PERT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dj_raw_c = W'(sat_sub(xw_t'(j_p), xw_t'(j_m), W));
    dj_c     = MODE ? W'(sat_sub(xw_t'(0), xw_t'(dj_raw_c), W)) : dj_raw_c;
    sum_c    = lfsr[5'(idx)] ? W'(sat_sub(xw_t'(u[idx]), xw_t'(step), W))
                             : W'(sat_add(xw_t'(u[idx]), xw_t'(step), W));
    if (sum_c < U_MIN)      upd_c = U_MIN;
    else if (sum_c > U_MAX) upd_c = U_MAX;
    else                    upd_c = sum_c;
  end

  // Per-channel DAC register: perturbed value while sampling, committed U otherwise
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic signed [W-1:0] up_c, dn_c, hold_c, dac_nxt_c, dac;

    assign up_c   = W'(sat_add(xw_t'(u[k]), xw_t'(SIGMA), W));
    assign dn_c   = W'(sat_sub(xw_t'(u[k]), xw_t'(SIGMA), W));
    assign hold_c = (state == ST_UPD && idx == IW'(k)) ? upd_c : u[k];

    always_comb begin
      dac_nxt_c = hold_c;
      case (state_nxt)
        ST_SETP, ST_SAMPP: dac_nxt_c = lfsr_nxt[k] ? dn_c : up_c;
        ST_SETM, ST_SAMPM: dac_nxt_c = lfsr_nxt[k] ? up_c : dn_c;
        default:           dac_nxt_c = hold_c;
      endcase
    end

    always_ff @(posedge ADC_CLK or posedge REG_RST) begin
      if (REG_RST) dac <= U_RST_VAL;
      else         dac <= dac_nxt_c;
    end

    assign DAC_OUT[k*W +: W] = dac;
    assign U_OUT[k*W +: W]   = u[k];
  end

  assign ITER_CNT  = iter_cnt;
  assign BUSY      = busy;
  assign ADC_ERR   = adc_err;
  assign FSM_STATE = state;

endmodule

// File: tb/tb_spgd_multi_core.sv
// Directed bench for spgd_multi_core with a hand-driven ADC and hand-computed expectations.
module tb_spgd_multi_core;

  logic        clk = 1'b0;
  logic        rst, sys_en, mode, adc_done, adc_en, busy, adc_err;
  logic [31:0] adc_in, sigma, gamma, u_min, u_max, iter_cnt;
  logic [15:0] settle;
  logic [63:0] dac_out, u_out;
  logic [3:0]  fsm_state;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int n;

  always #5 clk = ~clk;

  spgd_multi_core dut (
    .ADC_CLK    (clk),
    .REG_RST    (rst),
    .SYS_EN     (sys_en),
    .MODE       (mode),
    .ADC_IN     (adc_in),
    .ADC_DONE   (adc_done),
    .ADC_EN     (adc_en),
    .SIGMA      (sigma),
    .GAMMA      (gamma),
    .U_MIN      (u_min),
    .U_MAX      (u_max),
    .SETTLE_CYC (settle),
    .DAC_OUT    (dac_out),
    .U_OUT      (u_out),
    .ITER_CNT   (iter_cnt),
    .BUSY       (busy),
    .ADC_ERR    (adc_err),
    .FSM_STATE  (fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (fsm_state !== s && k < 10000);
    check(tag, 64'(fsm_state), 64'(s));
  endtask

  task automatic wait_adc(output int cnt, input string tag);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (adc_en !== 1'b1 && cnt < 10000);
    check(tag, 64'(adc_en), 64'(1));
  endtask

  task automatic wait_iter(input logic [31:0] v, output int cnt, input string tag);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (iter_cnt !== v && cnt < 10000);
    check(tag, 64'(iter_cnt), 64'(v));
  endtask

  // Called at the negedge where ADC_EN is seen: answer in that same cycle
  task automatic serve(input logic [31:0] v);
    adc_done = 1'b1;
    adc_in   = v;
    @(posedge clk);
    #1;
    adc_done = 1'b0;
    adc_in   = '0;
    check("adc_en_one_cycle", 64'(adc_en), 64'(0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    sys_en   = 1'b0;
    adc_done = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    sys_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; sys_en = 1'b0; mode = 1'b0; adc_done = 1'b0; adc_in = '0;
    sigma = 32'h0000_1000; gamma = 32'h0001_0000;
    u_min = 32'h8000_0000; u_max = 32'h7FFF_FFFF; settle = 16'd3;

    repeat (2) @(negedge clk);
    check("rst_state",  64'(fsm_state), 64'(0));
    check("rst_busy",   64'(busy),      64'(0));
    check("rst_iter",   64'(iter_cnt),  64'(0));
    check("rst_u",      u_out,          64'h0);
    check("rst_dac",    dac_out,        64'h0);
    check("rst_adc_en", 64'(adc_en),    64'(0));
    check("rst_err",    64'(adc_err),   64'(0));
    @(posedge clk); #1; rst = 1'b0; sys_en = 1'b1;

    // Iteration 1: LFSR bits [1:0] = 00, both channels step up
    wait_state(4'd2, "enter_setp_1");
    check("dac_setp_1", dac_out, 64'h00001000_00001000);
    wait_adc(n, "adc_en_p1");
    check("settle_lat_p1", 64'(n), 64'(4));
    serve(32'h0002_0000);
    wait_state(4'd4, "enter_setm_1");
    check("dac_setm_1", dac_out, 64'hFFFFF000_FFFFF000);
    wait_adc(n, "adc_en_m1");
    check("settle_lat_m1", 64'(n), 64'(4));
    serve(32'h0001_0000);
    wait_iter(32'd1, n, "iter_1");
    check("upd_latency", 64'(n), 64'(5));
    check("u_iter1", u_out, 64'h00001000_00001000);
    check("pert_after_upd", 64'(fsm_state), 64'(1));

    // Iteration 2: LFSR bits [1:0] = 10, channel 1 perturbed and stepped down
    wait_state(4'd2, "enter_setp_2");
    check("dac_setp_2", dac_out, 64'h00000000_00002000);
    wait_adc(n, "adc_en_p2");
    serve(32'h0002_0000);
    wait_adc(n, "adc_en_m2");
    serve(32'h0001_0000);
    wait_iter(32'd2, n, "iter_2");
    check("u_iter2", u_out, 64'h00000000_00002000);

    // Reset while waiting in SAMPP with ADC_DONE high
    wait_adc(n, "adc_en_p3");
    adc_done = 1'b1;
    rst      = 1'b1;
    #1;
    check("midrst_state", 64'(fsm_state), 64'(0));
    check("midrst_u",     u_out,          64'h0);
    check("midrst_dac",   dac_out,        64'h0);
    check("midrst_iter",  64'(iter_cnt),  64'(0));
    check("midrst_busy",  64'(busy),      64'(0));
    @(negedge clk);
    check("midrst_hold_state", 64'(fsm_state), 64'(0));
    check("midrst_adc_en",     64'(adc_en),    64'(0));
    adc_done = 1'b0;
    mode     = 1'b1;
    @(posedge clk); #1; rst = 1'b0;

    // Minimise mode: same data, steps reversed
    wait_state(4'd2, "enter_setp_min");
    wait_adc(n, "adc_en_pmin");
    serve(32'h0002_0000);
    wait_adc(n, "adc_en_mmin");
    serve(32'h0001_0000);
    wait_iter(32'd1, n, "iter_min");
    check("u_min_mode", u_out, 64'hFFFFF000_FFFFF000);

    // Upper clamp at 0x800
    mode  = 1'b0;
    u_max = 32'h0000_0800;
    do_reset();
    wait_state(4'd2, "enter_setp_cl1");
    wait_adc(n, "adc_en_cl1p");
    serve(32'h0002_0000);
    wait_adc(n, "adc_en_cl1m");
    serve(32'h0001_0000);
    wait_iter(32'd1, n, "iter_cl1");
    check("u_clamp_1", u_out, 64'h00000800_00000800);
    wait_state(4'd2, "enter_setp_cl2");
    check("dac_setp_cl2", dac_out, 64'hFFFFF800_00001800);
    wait_adc(n, "adc_en_cl2p");
    serve(32'h0002_0000);
    wait_adc(n, "adc_en_cl2m");
    serve(32'h0001_0000);
    wait_iter(32'd2, n, "iter_cl2");
    check("u_clamp_2", u_out, 64'hFFFFF800_00000800);

    // Saturation of adds, subtracts and products at the word limits
    u_max = 32'h7FFF_FFFF;
    sigma = 32'h7FFF_FFFF;
    gamma = 32'h7FFF_FFFF;
    do_reset();
    wait_state(4'd2, "enter_setp_sat");
    check("dac_setp_sat1", dac_out, 64'h7FFFFFFF_7FFFFFFF);
    wait_adc(n, "adc_en_satp");
    serve(32'h7FFF_FFFF);
    wait_state(4'd4, "enter_setm_sat");
    check("dac_setm_sat1", dac_out, 64'h80000001_80000001);
    wait_adc(n, "adc_en_satm");
    serve(32'h8000_0000);
    wait_iter(32'd1, n, "iter_sat");
    check("u_sat", u_out, 64'h7FFFFFFF_7FFFFFFF);
    wait_state(4'd2, "enter_setp_sat2");
    check("dac_setp_sat2", dac_out, 64'h00000000_7FFFFFFF);

    // ADC timeout
    sigma = 32'h0000_1000;
    gamma = 32'h0001_0000;
    do_reset();
    wait_adc(n, "adc_en_to");
    n = 0;
    do begin @(negedge clk); n++; end while (adc_err !== 1'b1 && n < 5000);
    check("timeout_cycles", 64'(n), 64'(4096));
    check("timeout_err",    64'(adc_err),   64'(1));
    check("timeout_state",  64'(fsm_state), 64'(1));
    check("timeout_u",      u_out,          64'h0);
    check("timeout_iter",   64'(iter_cnt),  64'(0));
    repeat (10) @(negedge clk);
    check("timeout_sticky", 64'(adc_err),   64'(1));

    // SYS_EN dropped in SETM: finish the iteration, then idle
    do_reset();
    wait_state(4'd2, "enter_setp_en");
    wait_adc(n, "adc_en_enp");
    serve(32'h0002_0000);
    sys_en = 1'b0;
    wait_adc(n, "adc_en_enm");
    serve(32'h0001_0000);
    wait_iter(32'd1, n, "iter_en");
    check("en_pert",   64'(fsm_state), 64'(1));
    check("en_busy1",  64'(busy),      64'(1));
    @(negedge clk);
    check("en_idle",   64'(fsm_state), 64'(0));
    check("en_busy0",  64'(busy),      64'(0));
    repeat (5) @(negedge clk);
    check("en_iter_hold", 64'(iter_cnt), 64'(1));
    check("en_u",         u_out,         64'h00001000_00001000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
